// File: rtl/core_sequencer.sv
// Multi-cycle sequencer for the RV32I core: PC/instruction ownership, fetch and data handshakes, WB commit gating.
// Optional bus wait timeout enabled by defining SEQ_BUS_TIMEOUT_EN.
module core_sequencer #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_rdata_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    input  logic [31:0] pc_next_in,
    input  logic        dmem_rd_en_in,
    input  logic        dmem_wr_en_in,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    input  logic        dmem_ack_in,
    input  logic [31:0] dmem_rdata_in,
    output logic [31:0] dmem_rd_data_out,
    input  logic        reg_wr_en_in,
    output logic        reg_wr_en_out,
    input  logic        halt_in,
    output logic        halted_out,
    output logic [31:0] instret_out,
    output logic        bus_err_out
);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4,
        HALT  = 3'd5
    } state_t;

    state_t state, state_next;
    logic   timeout_hit;

`ifdef SEQ_BUS_TIMEOUT_EN
    logic [31:0] wait_cnt;
    logic        bus_err_q;

    // Counter restarts on every state change, so each FETCH/MEM visit gets a fresh budget.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (state_next != state)
                wait_cnt <= '0;
            else if ((state == FETCH && !imem_ack_in) || (state == MEM && !dmem_ack_in))
                wait_cnt <= wait_cnt + 32'd1;
            if (timeout_hit)
                bus_err_q <= 1'b1;
        end
    end

    always_comb begin
        timeout_hit = 1'b0;
        if ((state == FETCH && !imem_ack_in) || (state == MEM && !dmem_ack_in))
            timeout_hit = (wait_cnt == 32'(TIMEOUT_CYCLES - 1));
    end

    assign bus_err_out = bus_err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus_err_out = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            BOOT:  state_next = FETCH;
            FETCH: if (imem_ack_in) state_next = EXEC;
            EXEC: begin
                if (halt_in)
                    state_next = HALT;
                else if (dmem_rd_en_in || dmem_wr_en_in)
                    state_next = MEM;
                else
                    state_next = WB;
            end
            MEM:   if (dmem_ack_in) state_next = WB;
            WB:    state_next = FETCH;
            HALT:  state_next = HALT;
            default: state_next = BOOT;
        endcase
        if (timeout_hit)
            state_next = HALT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= BOOT;
            pc_out           <= RESET_PC;
            instr_out        <= NOP_INSTR;
            dmem_rd_data_out <= '0;
            instret_out      <= '0;
        end else begin
            state <= state_next;
            if (state == FETCH && imem_ack_in)
                instr_out <= imem_rdata_in;
            if (state == MEM && dmem_ack_in && !dmem_wr_en_in)
                dmem_rd_data_out <= dmem_rdata_in;
            if (state == WB) begin
                pc_out      <= pc_next_in;
                instret_out <= instret_out + 32'd1;
            end
        end
    end

    // Requests are gated by rst so an aborted handshake drops in the reset cycle itself.
    assign imem_req_out  = (state == FETCH) && !rst;
    assign dmem_req_out  = (state == MEM) && !rst;
    assign dmem_we_out   = dmem_req_out && dmem_wr_en_in;
    assign imem_addr_out = pc_out;
    assign reg_wr_en_out = (state == WB) && reg_wr_en_in;
    assign halted_out    = (state == HALT);

endmodule
